vga_scanout: RTL and testbench

- Parametrised successor to the fixed 640x480 monochrome VGA block.
- Generates sync timing from parameters and centres a FB_WIDTH x FB_HEIGHT 1-bpp framebuffer window in the active area.
- Prefetches 16-bit VRAM words through a two-stage word buffer that tolerates a parametrised read latency.
- Maps pixels to programmable foreground/background colours and adds frame/blank status outputs; sits between the VRAM read port and the board VGA pins.

---
 rtl/vga_scanout.sv | 163 ++++++++++++++++
 tb/tb_vga_scanout.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out: sync timing, centred 1-bpp framebuffer window,
// latency-tolerant VRAM word prefetch, colour mapping and status outputs.
`timescale 1ns/1ps
module vga_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_NEG  = 1,
    parameter int FB_WIDTH  = 512,
    parameter int FB_HEIGHT = 256,
    parameter int READ_LAT  = 3,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       vram_rdata,
    output logic [ADDR_W-1:0] vram_raddr,
    output logic              vram_rden,
    input  logic [11:0]       fg_colour,
    input  logic [11:0]       bg_colour,
    input  logic [11:0]       border_colour,
    output logic              h_sync,
    output logic              v_sync,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              blank,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IW      = HW - 4;
    localparam int X_OFF   = (H_ACTIVE - FB_WIDTH) / 2;
    localparam int Y_OFF   = (V_ACTIVE - FB_HEIGHT) / 2;
    localparam int WORDS   = FB_WIDTH / 16;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_START  = HW'(X_OFF);
    localparam logic [HW-1:0] X_END    = HW'(X_OFF + FB_WIDTH);
    localparam logic [HW-1:0] FETCH_H  = HW'(X_OFF - 16);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_START  = VW'(Y_OFF);
    localparam logic [VW-1:0] Y_END    = VW'(Y_OFF + FB_HEIGHT);
    localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);
    localparam logic          SYNC_IDLE = (SYNC_NEG != 0);

    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    logic [READ_LAT-1:0] strobe_q, strobe_d;
    logic [15:0]         next_word_q, next_word_d;
    logic [15:0]         current_word_q, current_word_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                h_sync_q, h_sync_d;
    logic                v_sync_q, v_sync_d;
    logic                blank_q, blank_d;
    logic                frame_start_q, frame_start_d;
    logic [11:0]         rgb_q, rgb_d;

    logic [HW-1:0]     win_x;
    logic [VW-1:0]     win_y;
    logic [IW-1:0]     word_idx, rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       pix_word;
    logic              fetch_line, in_win, word_start, active, pix_bit;

    // Read-strobe delay line: bit READ_LAT-1 marks the cycle vram_rdata is valid.
    assign strobe_d[0] = vram_rden;
    for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_strobe
        assign strobe_d[gi] = strobe_q[gi-1];
    end

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end

        win_x      = h_cnt_q - X_START;
        win_y      = v_cnt_q - Y_START;
        word_idx   = win_x[HW-1:4];
        fetch_line = (v_cnt_q >= Y_START) && (v_cnt_q < Y_END);
        in_win     = fetch_line && (h_cnt_q >= X_START) && (h_cnt_q < X_END);
        word_start = in_win && (win_x[3:0] == 4'd0);
        active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

        // Word 0 is fetched ahead of the window; each word boundary fetches the next.
        rd_idx     = (h_cnt_q == FETCH_H) ? '0 : word_idx + IW'(1);
        rd_addr    = ADDR_W'(win_y) * ADDR_W'(WORDS) + ADDR_W'(rd_idx);
        vram_rden  = !reset && fetch_line &&
                     ((h_cnt_q == FETCH_H) || (word_start && (word_idx != LAST_WORD)));
        vram_raddr = vram_rden ? rd_addr : raddr_q;
        raddr_d    = vram_raddr;

        next_word_d    = strobe_q[READ_LAT-1] ? vram_rdata : next_word_q;
        current_word_d = word_start ? next_word_q : current_word_q;
        pix_word       = word_start ? next_word_q : current_word_q;
        pix_bit        = pix_word[win_x[3:0]];

        rgb_d = 12'h000;
        if (active) begin
            if (in_win) begin
                rgb_d = pix_bit ? fg_colour : bg_colour;
            end else begin
                rgb_d = border_colour;
            end
        end
        h_sync_d      = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ^ SYNC_IDLE;
        v_sync_d      = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ^ SYNC_IDLE;
        blank_d       = !active;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            strobe_q       <= '0;
            next_word_q    <= '0;
            current_word_q <= '0;
            raddr_q        <= '0;
            h_sync_q       <= SYNC_IDLE;
            v_sync_q       <= SYNC_IDLE;
            blank_q        <= 1'b1;
            frame_start_q  <= 1'b0;
            rgb_q          <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            strobe_q       <= strobe_d;
            next_word_q    <= next_word_d;
            current_word_q <= current_word_d;
            raddr_q        <= raddr_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
            blank_q        <= blank_d;
            frame_start_q  <= frame_start_d;
            rgb_q          <= rgb_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two reduced-timing instances (read latency 3 and 14),
// per-pixel scoreboard against an image model, plus fetch and frame checks.
`timescale 1ns/1ps
module tb_vga_scanout;
    // Reduced timing: 140 x 28 total, 112 x 20 active, 48 x 12 window at (32,4).
    localparam int HA = 112, HF = 8, HS = 12, HB = 8, HT = HA + HF + HS + HB;
    localparam int VA = 20,  VF = 3, VS = 2,  VB = 3, VT = VA + VF + VS + VB;
    localparam int FBW = 48, FBH = 12, XO = 32, YO = 4, W16 = 3, AW = 13;
    localparam int FRAME = 3920;
    localparam int STROBES_PER_LINE = 3;
    localparam int FRAMES_EXPECTED = 6;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] fg, bg, bd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] vram_word(logic [AW-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        if (int'(a) < W16) return 16'h0001;
        return (a16 * 16'h9E37) ^ {a16[7:0], a16[15:8]} ^ 16'hC3A5;
    endfunction

    function automatic exp_t model_px(int h, int v, int sneg, logic rst,
                                      logic [11:0] fgc, logic [11:0] bgc, logic [11:0] bdc);
        exp_t        e;
        int          wx, wy;
        logic [15:0] w;
        e.h = 16'(h);
        e.v = 16'(v);
        if (rst) begin
            e.hs = (sneg != 0); e.vs = (sneg != 0); e.bl = 1'b1; e.fs = 1'b0; e.rgb = 12'h000;
            return e;
        end
        e.hs  = (h >= HA + HF && h < HA + HF + HS) ^ (sneg != 0);
        e.vs  = (v >= VA + VF && v < VA + VF + VS) ^ (sneg != 0);
        e.bl  = !(h < HA && v < VA);
        e.fs  = (h == 0 && v == 0);
        e.rgb = 12'h000;
        if (!e.bl) begin
            if (h >= XO && h < XO + FBW && v >= YO && v < YO + FBH) begin
                wx = h - XO;
                wy = v - YO;
                w = vram_word(AW'(wy * W16 + wx / 16));
                e.rgb = w[wx % 16] ? fgc : bgc;
            end else begin
                e.rgb = bdc;
            end
        end
        return e;
    endfunction

    function automatic logic rden_exp(int h, int v);
        if (v < YO || v >= YO + FBH) return 1'b0;
        if (h == XO - 16) return 1'b1;
        if (h >= XO && h < XO + FBW - 16 && (h - XO) % 16 == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] addr_exp(int h, int v);
        int idx;
        idx = (h == XO - 16) ? 0 : (h - XO) / 16 + 1;
        return AW'((v - YO) * W16 + idx);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT  = (gi == 0) ? 3 : 14;
        localparam int SNEG = (gi == 0) ? 1 : 0;

        logic [15:0]   rdata = 16'h0000;
        logic [AW-1:0] raddr;
        logic          rden, hs, vs, bl, fs;
        logic [3:0]    r, g, b;
        logic          pv [0:LAT];
        logic [AW-1:0] pa [0:LAT];
        exp_t          q [$];
        int            mh = 0, mv = 0, since = 0, prev_fs = -1, fs_seen = 0, strobes = 0;

        vga_scanout #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .SYNC_NEG(SNEG), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
            .READ_LAT(LAT), .ADDR_W(AW)
        ) u_dut (
            .clk(clk), .reset(reset),
            .vram_rdata(rdata), .vram_raddr(raddr), .vram_rden(rden),
            .fg_colour(fg), .bg_colour(bg), .border_colour(bd),
            .h_sync(hs), .v_sync(vs), .red(r), .green(g), .blue(b),
            .blank(bl), .frame_start(fs)
        );

        initial begin
            for (int i = 0; i <= LAT; i++) begin
                pv[i] = 1'b0;
                pa[i] = '0;
            end
        end

        // VRAM: data for a strobe seen in cycle t is presented during cycle t+LAT,
        // and a poison value otherwise.
        always @(negedge clk) begin : vram_model
            for (int i = LAT; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = rden;
            pa[0] = raddr;
            rdata = (pv[LAT] === 1'b1) ? vram_word(pa[LAT]) : 16'hDEAD;
        end

        // Expected registered outputs for the cycle ending at this edge.
        always @(posedge clk) begin : model
            exp_t e;
            e = model_px(mh, mv, SNEG, reset, fg, bg, bd);
            q.push_back(e);
            if (reset) begin
                mh = 0;
                mv = 0;
            end else begin
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
            end
        end

        always @(negedge clk) begin : monitor
            exp_t        e;
            logic [11:0] rgb;
            logic        want_rden;
            int          want;
            rgb = {r, g, b};
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({hs, vs, bl, fs, rgb} !== {e.hs, e.vs, e.bl, e.fs, e.rgb}) begin
                    errors++;
                    $display("FAIL dut%0d video h=%0d v=%0d: got hs=%b vs=%b blank=%b fs=%b rgb=%h, want hs=%b vs=%b blank=%b fs=%b rgb=%h",
                             gi, e.h, e.v, hs, vs, bl, fs, rgb, e.hs, e.vs, e.bl, e.fs, e.rgb);
                end
            end

            want_rden = !reset && rden_exp(mh, mv);
            checks++;
            if (rden !== want_rden) begin
                errors++;
                $display("FAIL dut%0d rden h=%0d v=%0d: got %b, want %b", gi, mh, mv, rden, want_rden);
            end else if (rden === 1'b1) begin
                checks++;
                if (raddr !== addr_exp(mh, mv)) begin
                    errors++;
                    $display("FAIL dut%0d raddr h=%0d v=%0d: got %0d, want %0d",
                             gi, mh, mv, raddr, addr_exp(mh, mv));
                end
            end

            if (reset) begin
                strobes = 0;
                since   = 0;
                prev_fs = -1;
            end else begin
                since++;
                if (rden === 1'b1) strobes++;
                if (mh == HT - 1) begin
                    want = (mv >= YO && mv < YO + FBH) ? STROBES_PER_LINE : 0;
                    checks++;
                    if (strobes != want) begin
                        errors++;
                        $display("FAIL dut%0d strobes_per_line v=%0d: got %0d, want %0d", gi, mv, strobes, want);
                    end
                    strobes = 0;
                end
                if (fs === 1'b1) begin
                    fs_seen++;
                    // First pulse follows the first clock edge out of reset.
                    want = (prev_fs < 0) ? 2 : prev_fs + FRAME;
                    checks++;
                    if (since != want) begin
                        errors++;
                        $display("FAIL dut%0d frame_start_timing: got cycle %0d, want %0d", gi, since, want);
                    end
                    $display("dut%0d frame_start #%0d at cycle %0d after reset", gi, fs_seen, since);
                    prev_fs = since;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        fg = 12'hF80;
        bg = 12'h024;
        bd = 12'h555;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5000) @(posedge clk);
        #2 begin
            fg = 12'h0F0;
            bg = 12'h300;
            bd = 12'hABC;
        end
        // Reset lands mid-window on line 8 of the third frame, with reads in flight.
        repeat (4000) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (7940) @(posedge clk);
        #2;
        checks++;
        if (g_dut[0].fs_seen != FRAMES_EXPECTED) begin
            errors++;
            $display("FAIL dut0 frame_count: got %0d, want %0d", g_dut[0].fs_seen, FRAMES_EXPECTED);
        end
        checks++;
        if (g_dut[1].fs_seen != FRAMES_EXPECTED) begin
            errors++;
            $display("FAIL dut1 frame_count: got %0d, want %0d", g_dut[1].fs_seen, FRAMES_EXPECTED);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
